// File: rtl/score_tally_if.sv
`timescale 1ns/1ps
// score_tally_if: bundles the score_tally game inputs and statistic outputs.
//   master : the drivers of keycode/hit_vec/miss_vec, which also read the statistics
//   slave  : score_tally itself
//   keycode    8        primary USB keycode
//   hit_vec    N_DROPS  level hit flag per dropper
//   miss_vec   N_DROPS  level miss flag per dropper
//   score      14       binary score
//   score_bcd  16       4-digit BCD of score
//   combo, max_combo, hit_count, miss_count  10 each
//   playing, finished   1 each
interface score_tally_if #(
  parameter int N_DROPS = 64
);
  logic [7:0]         keycode;
  logic [N_DROPS-1:0] hit_vec;
  logic [N_DROPS-1:0] miss_vec;
  logic [13:0]        score;
  logic [15:0]        score_bcd;
  logic [9:0]         combo;
  logic [9:0]         max_combo;
  logic [9:0]         hit_count;
  logic [9:0]         miss_count;
  logic               playing;
  logic               finished;

  modport master (
    output keycode, hit_vec, miss_vec,
    input  score, score_bcd, combo, max_combo, hit_count, miss_count, playing, finished
  );

  modport slave (
    input  keycode, hit_vec, miss_vec,
    output score, score_bcd, combo, max_combo, hit_count, miss_count, playing, finished
  );
endinterface

// File: rtl/score_tally.sv
`timescale 1ns/1ps
// score_tally: turns per-dropper hit/miss level flags into game statistics
// (score, combo, max combo, hit and miss counts) and runs the
// Halted -> Play -> End game flow driven by the keyboard.
// Ports:
//   frame_clk  in   frame-rate clock shared with the droppers
//   Reset      in   synchronous, active-high reset
//   bus        slave modport of score_tally_if (keycode, hit_vec, miss_vec in;
//              score, score_bcd, combo, max_combo, hit_count, miss_count,
//              playing, finished out)
module score_tally #(
  parameter int N_DROPS     = 64,
  parameter int SONG_FRAMES = 3600,
  parameter int SCORE_MAX   = 9999,
  parameter int COMBO_MAX   = 1023
) (
  input  logic          frame_clk,
  input  logic          Reset,
  score_tally_if.slave  bus
);

  localparam int CNT_W   = $clog2(N_DROPS + 1);
  localparam int FRAME_W = (SONG_FRAMES > 1) ? $clog2(SONG_FRAMES) : 1;

  localparam logic [7:0]         KEY_START   = 8'h2C;
  localparam logic [7:0]         KEY_RESTART = 8'h01;
  localparam logic [13:0]        SCORE_MAX_V = 14'(SCORE_MAX);
  localparam logic [9:0]         COMBO_MAX_V = 10'(COMBO_MAX);
  localparam logic [FRAME_W-1:0] LAST_FRAME  = FRAME_W'(SONG_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_PLAY   = 2'd1,
    ST_END    = 2'd2
  } state_t;

  // Number of set bits in a flag vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_DROPS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_DROPS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Score add with saturation; 16-bit sum cannot wrap before the clamp.
  function automatic logic [13:0] sat_score(input logic [13:0] a, input logic [CNT_W-1:0] b);
    logic [15:0] s;
    s = {2'b00, a} + 16'(b);
    if (s > 16'(SCORE_MAX)) begin
      return SCORE_MAX_V;
    end else begin
      return s[13:0];
    end
  endfunction

  // 10-bit counter add with saturation at COMBO_MAX.
  function automatic logic [9:0] sat_cnt(input logic [9:0] a, input logic [CNT_W-1:0] b);
    logic [15:0] s;
    s = {6'b000000, a} + 16'(b);
    if (s > 16'(COMBO_MAX)) begin
      return COMBO_MAX_V;
    end else begin
      return s[9:0];
    end
  endfunction

  // Double-dabble conversion of the 14-bit score into four BCD digits.
  function automatic logic [15:0] to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'h0000, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14 + 4*d +: 4] >= 4'd5) begin
          sh[14 + 4*d +: 4] = sh[14 + 4*d +: 4] + 4'd3;
        end else begin
          sh[14 + 4*d +: 4] = sh[14 + 4*d +: 4];
        end
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [13:0]        score_q, score_d;
  logic [9:0]         combo_q, combo_d;
  logic [9:0]         max_combo_q, max_combo_d;
  logic [9:0]         hit_count_q, hit_count_d;
  logic [9:0]         miss_count_q, miss_count_d;
  logic [N_DROPS-1:0] hit_prev_q, hit_prev_d;
  logic [N_DROPS-1:0] miss_prev_q, miss_prev_d;
  logic               playing_q, playing_d;
  logic               finished_q, finished_d;

  logic [CNT_W-1:0]   h_s;
  logic [CNT_W-1:0]   m_s;
  logic [9:0]         combo_next_s;

  // Next-state and statistics update for the game flow.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    score_d      = score_q;
    combo_d      = combo_q;
    max_combo_d  = max_combo_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    // prev registers track in every state so flags already high on entry to Play never count
    hit_prev_d   = bus.hit_vec;
    miss_prev_d  = bus.miss_vec;

    h_s = popcount(bus.hit_vec & ~hit_prev_q);
    m_s = popcount(bus.miss_vec & ~miss_prev_q);

    // a miss in the frame breaks the combo even if hits landed alongside it
    if (m_s != '0) begin
      combo_next_s = 10'd0;
    end else begin
      combo_next_s = sat_cnt(combo_q, h_s);
    end

    case (state_q)
      ST_HALTED: begin
        frame_d      = '0;
        score_d      = 14'd0;
        combo_d      = 10'd0;
        max_combo_d  = 10'd0;
        hit_count_d  = 10'd0;
        miss_count_d = 10'd0;
        if (bus.keycode == KEY_START) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_PLAY: begin
        score_d      = sat_score(score_q, h_s);
        hit_count_d  = sat_cnt(hit_count_q, h_s);
        miss_count_d = sat_cnt(miss_count_q, m_s);
        combo_d      = combo_next_s;
        if (combo_next_s > max_combo_q) begin
          max_combo_d = combo_next_s;
        end else begin
          max_combo_d = max_combo_q;
        end
        if (frame_q == LAST_FRAME) begin
          state_d = ST_END;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end
      ST_END: begin
        // statistics clear on the same edge that leaves End
        if (bus.keycode == KEY_RESTART) begin
          state_d      = ST_HALTED;
          frame_d      = '0;
          score_d      = 14'd0;
          combo_d      = 10'd0;
          max_combo_d  = 10'd0;
          hit_count_d  = 10'd0;
          miss_count_d = 10'd0;
        end else begin
          state_d = ST_END;
        end
      end
      default: begin
        state_d      = ST_HALTED;
        frame_d      = '0;
        score_d      = 14'd0;
        combo_d      = 10'd0;
        max_combo_d  = 10'd0;
        hit_count_d  = 10'd0;
        miss_count_d = 10'd0;
      end
    endcase

    playing_d  = (state_d == ST_PLAY);
    finished_d = (state_d == ST_END);
  end

  // State, statistics and flag registers with synchronous reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ST_HALTED;
      frame_q      <= '0;
      score_q      <= 14'd0;
      combo_q      <= 10'd0;
      max_combo_q  <= 10'd0;
      hit_count_q  <= 10'd0;
      miss_count_q <= 10'd0;
      hit_prev_q   <= '0;
      miss_prev_q  <= '0;
      playing_q    <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      max_combo_q  <= max_combo_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      hit_prev_q   <= hit_prev_d;
      miss_prev_q  <= miss_prev_d;
      playing_q    <= playing_d;
      finished_q   <= finished_d;
    end
  end

  assign bus.score      = score_q;
  assign bus.score_bcd  = to_bcd(score_q);
  assign bus.combo      = combo_q;
  assign bus.max_combo  = max_combo_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
  assign bus.playing    = playing_q;
  assign bus.finished   = finished_q;

endmodule

// File: tb/tb_score_tally.sv
`timescale 1ns/1ps
// tb_score_tally: scoreboard bench for score_tally. Every driven frame runs a
// behavioural model whose expected outputs are queued and compared after the edge.
module tb_score_tally;

  localparam int NDROPS = 64;
  localparam int FRAMES = 3600;

  logic frame_clk;
  logic Reset;

  score_tally_if #(.N_DROPS(NDROPS)) bus ();

  score_tally #(
    .N_DROPS(NDROPS), .SONG_FRAMES(FRAMES), .SCORE_MAX(9999), .COMBO_MAX(1023)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int score; int bcd; int combo; int maxc; int hits; int misses; int playing; int finished;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  // model state
  int          m_st, m_frame, m_score, m_combo, m_max, m_hits, m_miss;
  logic [63:0] m_phit, m_pmiss;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_frame = 0; m_score = 0; m_combo = 0; m_max = 0; m_hits = 0; m_miss = 0;
  endtask

  task automatic model_step(input logic rst, input logic [7:0] key,
                            input logic [63:0] hv, input logic [63:0] mv);
    int h, m, cn, s;
    exp_t e;
    if (rst) begin
      m_st = 0; model_clear(); m_phit = '0; m_pmiss = '0;
    end else begin
      h = $countones(hv & ~m_phit);
      m = $countones(mv & ~m_pmiss);
      if (m_st == 0) begin
        model_clear();
        if (key == 8'h2C) m_st = 1;
      end else if (m_st == 1) begin
        m_score = imin(m_score + h, 9999);
        m_hits  = imin(m_hits + h, 1023);
        m_miss  = imin(m_miss + m, 1023);
        cn = (m != 0) ? 0 : imin(m_combo + h, 1023);
        m_combo = cn;
        if (cn > m_max) m_max = cn;
        if (m_frame == FRAMES - 1) m_st = 2;
        else m_frame = m_frame + 1;
      end else begin
        if (key == 8'h01) begin
          m_st = 0; model_clear();
        end
      end
      m_phit = hv; m_pmiss = mv;
    end
    s = m_score;
    e.score = s;
    e.bcd = ((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10);
    e.combo = m_combo; e.maxc = m_max; e.hits = m_hits; e.misses = m_miss;
    e.playing = (m_st == 1) ? 1 : 0;
    e.finished = (m_st == 2) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("score",     32'(bus.score),      e.score);
      check_eq("score_bcd", 32'(bus.score_bcd),  e.bcd);
      check_eq("combo",     32'(bus.combo),      e.combo);
      check_eq("max_combo", 32'(bus.max_combo),  e.maxc);
      check_eq("hit_count", 32'(bus.hit_count),  e.hits);
      check_eq("miss_count",32'(bus.miss_count), e.misses);
      check_eq("playing",   32'(bus.playing),    e.playing);
      check_eq("finished",  32'(bus.finished),   e.finished);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] key,
                      input logic [63:0] hv, input logic [63:0] mv);
    Reset = rst;
    bus.keycode = key;
    bus.hit_vec = hv;
    bus.miss_vec = mv;
    model_step(rst, key, hv, mv);
    @(posedge frame_clk);
    #1;
    compare_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hv;
    logic [63:0] all1;
    bit done;
    all1 = '1;
    Reset = 1'b1; bus.keycode = 8'h00; bus.hit_vec = '0; bus.miss_vec = '0;
    @(negedge frame_clk);

    // reset and start
    step(1'b1, 8'h00, 64'd0, 64'd0);
    step(1'b1, 8'h00, 64'd0, 64'd0);
    check_eq("rst_playing", 32'(bus.playing), 32'd0);
    check_eq("rst_finished", 32'(bus.finished), 32'd0);
    step(1'b0, 8'h2C, 64'd0, 64'd0);
    check_eq("start_playing", 32'(bus.playing), 32'd1);
    check_eq("start_bcd", 32'(bus.score_bcd), 32'h0000);

    // held hit counts once
    hv = 64'd1 << 3;
    repeat (50) step(1'b0, 8'h00, hv, 64'd0);
    check_eq("hold_score", 32'(bus.score), 32'd1);
    check_eq("hold_combo", 32'(bus.combo), 32'd1);

    // three hits with a miss in the same frame
    step(1'b0, 8'h00, 64'h7, 64'h20);
    check_eq("mix_score", 32'(bus.score), 32'd4);
    check_eq("mix_miss", 32'(bus.miss_count), 32'd1);
    check_eq("mix_combo", 32'(bus.combo), 32'd0);
    check_eq("mix_max", 32'(bus.max_combo), 32'd1);

    // combo to 7, miss, two hits
    hv = 64'h7;
    for (int i = 10; i < 17; i++) begin
      hv = hv | (64'd1 << i);
      step(1'b0, 8'h00, hv, 64'h20);
    end
    check_eq("combo7", 32'(bus.combo), 32'd7);
    step(1'b0, 8'h00, hv, 64'h60);
    hv = hv | (64'd3 << 20);
    step(1'b0, 8'h00, hv, 64'h60);
    check_eq("combo2", 32'(bus.combo), 32'd2);
    check_eq("combo_max7", 32'(bus.max_combo), 32'd7);
    check_eq("score13", 32'(bus.score), 32'd13);

    // preload score to 9998 then saturate
    step(1'b0, 8'h00, 64'd0, 64'd0);
    for (int i = 0; i < 156; i++) begin
      step(1'b0, 8'h00, all1, 64'd0);
      step(1'b0, 8'h00, 64'd0, 64'd0);
    end
    step(1'b0, 8'h00, 64'd1, 64'd0);
    check_eq("score9998", 32'(bus.score), 32'd9998);
    check_eq("hits_sat", 32'(bus.hit_count), 32'd1023);
    step(1'b0, 8'h00, 64'd0, 64'd0);
    step(1'b0, 8'h00, 64'hE, 64'd0);
    check_eq("score_sat", 32'(bus.score), 32'd9999);
    check_eq("bcd_sat", 32'(bus.score_bcd), 32'h9999);

    // run out the song
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      step(1'b0, 8'h00, 64'd0, 64'd0);
      if (bus.finished === 1'b1) done = 1'b1;
    end
    check_eq("end_reached", 32'(done), 32'd1);
    check_eq("end_playing", 32'(bus.playing), 32'd0);
    step(1'b0, 8'h00, 64'h00FF, 64'h0F00);
    check_eq("end_frozen", 32'(bus.score), 32'd9999);
    step(1'b0, 8'h2C, 64'd0, 64'd0);
    check_eq("end_ign_start", 32'(bus.finished), 32'd1);
    step(1'b0, 8'h01, 64'd0, 64'd0);
    check_eq("restart_score", 32'(bus.score), 32'd0);
    check_eq("restart_fin", 32'(bus.finished), 32'd0);
    check_eq("restart_max", 32'(bus.max_combo), 32'd0);

    // reset mid-play with score 42; flags high at restart do not count
    step(1'b0, 8'h2C, 64'd0, 64'd0);
    hv = (64'd1 << 42) - 64'd1;
    step(1'b0, 8'h00, hv, 64'd0);
    check_eq("score42", 32'(bus.score), 32'd42);
    step(1'b1, 8'h00, hv, 64'd1);
    check_eq("midrst_score", 32'(bus.score), 32'd0);
    check_eq("midrst_playing", 32'(bus.playing), 32'd0);
    step(1'b0, 8'h2C, hv, 64'd1);
    repeat (3) step(1'b0, 8'h00, hv, 64'd1);
    check_eq("stale_score", 32'(bus.score), 32'd0);
    check_eq("stale_miss", 32'(bus.miss_count), 32'd0);
    check_eq("stale_playing", 32'(bus.playing), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
